// File: rtl/inst_encoder_if.sv
// inst_encoder_if: request/response bundle between an instruction producer and inst_encoder
//   request : in_valid, in_ready, opcode, funct3, funct7, rd, rs1, rs2, imm
//   response: out_valid, out_ready, inst_code, range_err, err_count
interface inst_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] inst_code;
  logic        range_err;
  logic [7:0]  err_count;
  modport master (
    output in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    input  in_ready, out_valid, inst_code, range_err, err_count
  );
  modport slave (
    input  in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    output in_ready, out_valid, inst_code, range_err, err_count
  );
endinterface

// File: rtl/inst_encoder.sv
// inst_encoder: encodes RV32 instruction fields into a word, buffered in a 2-entry FIFO
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : inst_encoder_if.slave (request fields in, encoded word/range_err/err_count out)
module inst_encoder (
  input logic clk,
  input logic rst_n,
  inst_encoder_if.slave bus
);
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  logic [6:0]  op;
  logic [31:0] im;
  logic        is_i, is_sh;
  logic        fit12, fit13, fit21, fit_sh;
  logic [31:0] code;
  logic        err;
  logic [32:0] mem [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count;
  logic [7:0]  errs;
  logic        push, pop;
  assign op = bus.opcode;
  assign im = bus.imm;
  // A value fits an N-bit signed field when all bits from N-1 upward agree.
  assign fit12  = &im[31:11] | ~|im[31:11];
  assign fit13  = &im[31:12] | ~|im[31:12];
  assign fit21  = &im[31:20] | ~|im[31:20];
  assign fit_sh = ~|im[31:5];
  assign is_i   = op == OP_LOAD || op == OP_JALR || (op == OP_IMM && bus.funct3 != 3'b101);
  assign is_sh  = op == OP_IMM && bus.funct3 == 3'b101;
  always_comb begin
    code = is_i          ? {im[11:0], bus.rs1, bus.funct3, bus.rd, op}
         : is_sh         ? {bus.funct7, im[4:0], bus.rs1, bus.funct3, bus.rd, op}
         : op == OP_ST   ? {im[11:5], bus.rs2, bus.rs1, bus.funct3, im[4:0], op}
         : op == OP_BR   ? {im[12], im[10:5], bus.rs2, bus.rs1, bus.funct3, im[4:1], im[11], op}
         : op == OP_JAL  ? {im[20], im[10:1], im[11], im[19:12], bus.rd, op}
         :                 {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, op};
    err  = is_i          ? ~fit12
         : is_sh         ? ~fit_sh
         : op == OP_ST   ? ~fit12
         : op == OP_BR   ? ~(fit13 & ~im[0])
         : op == OP_JAL  ? ~(fit21 & ~im[0])
         :                 1'b0;
  end
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;
  assign bus.in_ready  = count != 2'd2;
  assign bus.out_valid = count != 2'd0;
  // Gate the head with out_valid so the outputs read 0 whenever the FIFO is empty.
  assign bus.inst_code = bus.out_valid ? mem[rd_ptr][32:1] : 32'd0;
  assign bus.range_err = bus.out_valid & mem[rd_ptr][0];
  assign bus.err_count = errs;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      errs   <= 8'd0;
    end else begin
      if (push) mem[wr_ptr] <= {code, err};
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
      if (pop && mem[rd_ptr][0] && errs != 8'hFF) errs <= errs + 8'd1;
    end
  end
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed-vector self-checking bench for inst_encoder
module tb_inst_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  inst_encoder_if bus ();
  inst_encoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                     input logic [31:0] im);
    bus.opcode = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
    bus.rd = d;
    bus.rs1 = s1;
    bus.rs2 = s2;
    bus.imm = im;
    bus.in_valid = 1'b1;
  endtask
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!bus.in_ready && n < 20) begin
      step();
      n++;
    end
    if (!bus.in_ready) chk({tag, "_ready_timeout"}, 32'(bus.in_ready), 32'd1);
  endtask
  task automatic one(input string tag, input logic [6:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                     input logic [4:0] s2, input logic [31:0] im,
                     input logic [31:0] exp_code, input logic exp_err, input logic [7:0] exp_cnt);
    wait_ready(tag);
    req(op, f3, f7, d, s1, s2, im);
    step();
    bus.in_valid = 1'b0;
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_code"}, bus.inst_code, exp_code);
    chk({tag, "_err"}, 32'(bus.range_err), 32'(exp_err));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_cnt"}, 32'(bus.err_count), 32'(exp_cnt));
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    req(7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    bus.in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_code", bus.inst_code, 32'd0);
    chk("rst_err", 32'(bus.range_err), 32'd0);
    chk("rst_cnt", 32'(bus.err_count), 32'd0);
    one("addi",      7'b0010011, 3'b000, 7'd0,        5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF00093, 1'b0, 8'd0);
    one("sw",        7'b0100011, 3'b010, 7'd0,        5'd0, 5'd3, 5'd2, 32'd8,         32'h0021A423, 1'b0, 8'd0);
    one("beq",       7'b1100011, 3'b000, 7'd0,        5'd0, 5'd0, 5'd0, -32'sd4,       32'hFE000EE3, 1'b0, 8'd0);
    one("jal",       7'b1101111, 3'b000, 7'd0,        5'd1, 5'd0, 5'd0, 32'd2048,      32'h001000EF, 1'b0, 8'd0);
    one("addi_big",  7'b0010011, 3'b000, 7'd0,        5'd1, 5'd0, 5'd0, 32'd2048,      32'h80000093, 1'b1, 8'd1);
    one("lw_min",    7'b0000011, 3'b010, 7'd0,        5'd5, 5'd2, 5'd0, -32'sd2048,    32'h80012283, 1'b0, 8'd1);
    one("srai",      7'b0010011, 3'b101, 7'b0100000,  5'd3, 5'd4, 5'd0, 32'd7,         32'h40725193, 1'b0, 8'd1);
    one("srai_big",  7'b0010011, 3'b101, 7'b0100000,  5'd3, 5'd4, 5'd0, 32'd32,        32'h40025193, 1'b1, 8'd2);
    one("add_r",     7'b0110011, 3'b000, 7'd0,        5'd1, 5'd2, 5'd3, 32'h12345,     32'h003100B3, 1'b0, 8'd2);
    one("beq_odd",   7'b1100011, 3'b000, 7'd0,        5'd0, 5'd0, 5'd0, 32'd3,         32'h00000163, 1'b1, 8'd3);
    one("jal_over",  7'b1101111, 3'b000, 7'd0,        5'd0, 5'd0, 5'd0, 32'd1048576,   32'h8000006F, 1'b1, 8'd4);
    one("jal_max",   7'b1101111, 3'b000, 7'd0,        5'd0, 5'd0, 5'd0, 32'd1048574,   32'h7FFFF06F, 1'b0, 8'd4);
    one("sw_big",    7'b0100011, 3'b010, 7'd0,        5'd0, 5'd3, 5'd2, 32'd2048,      32'h8021A023, 1'b1, 8'd5);
    // Backpressure: three back-to-back addi requests with the consumer stalled.
    req(7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
    step();
    chk("bp_ready_1", 32'(bus.in_ready), 32'd1);
    req(7'b0010011, 3'b000, 7'd0, 5'd2, 5'd0, 5'd0, 32'd2);
    step();
    chk("bp_ready_2", 32'(bus.in_ready), 32'd0);
    req(7'b0010011, 3'b000, 7'd0, 5'd3, 5'd0, 5'd0, 32'd3);
    step();
    step();
    chk("bp_held_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_head_a", bus.inst_code, 32'h00100093);
    bus.out_ready = 1'b1;
    step();
    chk("bp_head_b", bus.inst_code, 32'h00200113);
    chk("bp_ready_b", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("bp_head_c", bus.inst_code, 32'h00300193);
    chk("bp_pushpop_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_pushpop_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.out_ready = 1'b0;
    chk("bp_drained", 32'(bus.out_valid), 32'd0);
    // Reset with two words buffered and a nonzero error count.
    req(7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4096);
    step();
    step();
    chk("mid_full", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    chk("mid_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_cnt", 32'(bus.err_count), 32'd0);
    chk("mid_code", bus.inst_code, 32'd0);
    // Saturation: stream 300 range-error words through with the consumer always ready.
    bus.out_ready = 1'b1;
    req(7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    step();
    chk("sat_err_flag", 32'(bus.range_err), 32'd1);
    for (int i = 0; i < 299; i++) step();
    bus.in_valid = 1'b0;
    step();
    chk("sat_empty", 32'(bus.out_valid), 32'd0);
    chk("sat_cnt", 32'(bus.err_count), 32'd255);
    bus.out_ready = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
